// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR with a serial (MSB-first) seed loader
// and a valid/ready output register.
module lfsr_gen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter int               MODE         = 0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_rand,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_wrap,
  output logic             o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] latch_shift;
  logic             load_bit;
  logic             step;

  always_comb begin
    next_val = '0;
    if (MODE == 0) begin
      next_val = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end else begin
      next_val = {1'b0, lfsr_q[WIDTH-1:1]} ^ ({WIDTH{lfsr_q[0]}} & TAPS);
    end
  end

  // Load cycle k shifts in latch bit WIDTH-1-k, so the seed enters MSB first.
  always_comb begin
    latch_shift = latch_q >> (CW'(WIDTH - 1) - cnt_q);
    load_bit    = latch_shift[0];
  end

  // Handshake: o_rand is offered while o_valid=1 and consumed on a cycle with
  // i_ready=1; a new value may replace it only when the slot is empty or
  // being consumed, and o_rand/o_valid hold while o_valid=1 and i_ready=0.
  assign step = (state_q == ST_RUN) && !i_load && i_en && (!valid_q || i_ready);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    rand_d  = rand_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_load) begin
          state_d = ST_LOAD;
          latch_d = i_seed;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (step) begin
          lfsr_d  = next_val;
          rand_d  = next_val;
          valid_d = 1'b1;
          wrap_d  = (next_val == seed_q);
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        lfsr_d  = {lfsr_q[WIDTH-2:0], load_bit};
        cnt_d   = cnt_q + 1'b1;
        valid_d = 1'b0;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          // An all-zero seed would lock the register up.
          if (latch_q == '0) begin
            lfsr_d = DEFAULT_SEED;
            seed_d = DEFAULT_SEED;
          end else begin
            seed_d = latch_q;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      lfsr_q  <= DEFAULT_SEED;
      seed_q  <= DEFAULT_SEED;
      latch_q <= '0;
      cnt_q   <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_rand      = rand_q;
  assign o_valid     = valid_q;
  assign o_wrap      = wrap_q;
  assign o_busy      = (state_q == ST_LOAD);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (WIDTH=8, TAPS=B8, Fibonacci): vector table
// plus hand-written load, stall, wrap and mid-load reset sequences.
module tb_lfsr_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_seed;
  logic         i_load;
  logic         i_en;
  logic         i_ready;
  logic [W-1:0] o_rand;
  logic         o_valid;
  logic         o_busy;
  logic         o_wrap;
  logic         o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_state;

  typedef struct {
    logic         en;
    logic         ready;
    logic [W-1:0] exp_rand;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[9];

  lfsr_gen #(
    .WIDTH(W), .TAPS(8'hB8), .MODE(0), .DEFAULT_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .i_seed(i_seed), .i_load(i_load), .i_en(i_en),
    .i_ready(i_ready), .o_rand(o_rand), .o_valid(o_valid), .o_busy(o_busy),
    .o_wrap(o_wrap), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // Feedback taps 7,5,4,3 written out from the 8'hB8 mask.
  function automatic logic [W-1:0] fib_next(input logic [W-1:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one step-eligible cycle: model value pushed now, popped after the edge.
  task automatic sb_step(input string name);
    logic [W-1:0] e;
    m_state = fib_next(m_state);
    exp_q.push_back(m_state);
    tick();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(o_rand), 32'(e));
      check({name, "_valid"}, 32'(o_valid), 32'd1);
    end
  endtask

  task automatic count_busy(output int busy_cnt, output int valid_leak);
    busy_cnt   = 0;
    valid_leak = 0;
    for (int k = 0; k < 20; k++) begin
      if (!o_busy) break;
      busy_cnt++;
      if (o_valid) valid_leak++;
      i_load = (k == 3);
      i_seed = (k == 3) ? 8'h3C : 8'h00;
      tick();
    end
    i_load = 1'b0;
  endtask

  task automatic do_reset;
    rst     = 1'b0;
    i_seed  = '0;
    i_load  = 1'b0;
    i_en    = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_state = 8'h01;
    exp_q.delete();
  endtask

  initial begin
    int           busy_cnt;
    int           valid_leak;
    int           wrap_cnt;
    int           wrap_at;
    int           repeats;
    bit [255:0]   seen;
    logic [W-1:0] hold_val;

    rst     = 1'b0;
    i_seed  = '0;
    i_load  = 1'b0;
    i_en    = 1'b0;
    i_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 8'h02, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h04, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h08, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h11, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h11, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h11, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h11, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h23, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 8'h47, 1'b1};

    #2;
    check("rst_rand", 32'(o_rand), 32'h0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wrap", 32'(o_wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      i_en    = vecs[i].en;
      i_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_rand", i), 32'(o_rand), 32'(vecs[i].exp_rand));
      check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
    end

    // Full period: exactly one wrap, on step 255, no earlier repeats.
    do_reset();
    i_en     = 1'b1;
    i_ready  = 1'b1;
    wrap_cnt = 0;
    wrap_at  = 0;
    repeats  = 0;
    seen     = '0;
    seen[1]  = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      sb_step("period");
      if (o_wrap) begin
        wrap_cnt++;
        wrap_at = i;
      end
      if (seen[o_rand] && i < 255) repeats++;
      seen[o_rand] = 1'b1;
    end
    check("wrap_count", 32'(wrap_cnt), 32'd1);
    check("wrap_step", 32'(wrap_at), 32'd255);
    check("wrap_value", 32'(o_rand), 32'h01);
    check("no_repeat", 32'(repeats), 32'd0);

    // Load A5 while a step is also eligible: load wins.
    i_load = 1'b1;
    i_seed = 8'hA5;
    tick();
    i_load = 1'b0;
    i_seed = 8'h00;
    check("load_prio_rand", 32'(o_rand), 32'h01);
    check("load_clr_valid", 32'(o_valid), 32'd0);
    check("load_wrap_low", 32'(o_wrap), 32'd0);
    count_busy(busy_cnt, valid_leak);
    check("load_busy_cycles", 32'(busy_cnt), 32'd8);
    check("load_valid_leak", 32'(valid_leak), 32'd0);
    check("load_done_valid", 32'(o_valid), 32'd0);
    m_state = 8'hA5;
    sb_step("load_a5_step");
    check("load_a5_4a", 32'(o_rand), 32'h4A);

    // Zero seed is replaced by the default.
    i_en   = 1'b0;
    i_load = 1'b1;
    i_seed = 8'h00;
    tick();
    i_load = 1'b0;
    count_busy(busy_cnt, valid_leak);
    check("zero_busy_cycles", 32'(busy_cnt), 32'd8);
    i_en    = 1'b1;
    i_ready = 1'b1;
    m_state = 8'h01;
    sb_step("zero_seed_step");
    check("zero_seed_02", 32'(o_rand), 32'h02);

    // Back-pressure: five stalled cycles, then one value per cycle.
    hold_val = o_rand;
    i_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_rand", i), 32'(o_rand), 32'(hold_val));
      check($sformatf("stall%0d_valid", i), 32'(o_valid), 32'd1);
    end
    i_ready = 1'b1;
    sb_step("release0");
    check("release0_04", 32'(o_rand), 32'h04);
    sb_step("release1");
    sb_step("release2");

    // Reset in the middle of a load.
    i_en   = 1'b0;
    i_load = 1'b1;
    i_seed = 8'h5A;
    tick();
    i_load = 1'b0;
    tick();
    tick();
    tick();
    check("midload_busy", 32'(o_busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_rand", 32'(o_rand), 32'h0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_wrap", 32'(o_wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    i_en    = 1'b1;
    i_ready = 1'b1;
    m_state = 8'h01;
    exp_q.delete();
    sb_step("post_rst_step");
    check("post_rst_02", 32'(o_rand), 32'h02);
    i_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR state width in bits, legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 8'hB8, meaning the feedback mask; bit i set means state[i] participates in feedback.
REQ-003 SHALL have parameter MODE, default 0, meaning 0 = Fibonacci and 1 = Galois.
REQ-004 SHALL have parameter DEFAULT_SEED, default 8'h01, meaning the reset seed and zero-seed substitute; it must be non-zero.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, a reset that is asynchronous and active-low.
REQ-007 SHALL have port i_seed, input, WIDTH bits, the seed value, sampled on the cycle i_load is accepted.
REQ-008 SHALL have port i_load, input, 1 bit, a request to start a serial seed load.
REQ-009 SHALL have port i_en, input, 1 bit, the step enable.
REQ-010 SHALL have port i_ready, input, 1 bit, the consumer ready for o_rand.
REQ-011 SHALL have port o_rand, output, WIDTH bits, the random value.
REQ-012 SHALL have port o_valid, output, 1 bit, flagging that o_rand holds an unconsumed value.
REQ-013 SHALL have port o_busy, output, 1 bit, high while in LOAD.
REQ-014 SHALL have port o_wrap, output, 1 bit, a one-cycle pulse when the state returns to its seed value.

Function
REQ-015 SHALL implement an FSM with states RUN and LOAD and a load counter of clog2(WIDTH+1) bits.
REQ-016 SHALL compute the Fibonacci step (MODE=0) as: fb = XOR of state[i] over all TAPS[i]=1; next = {state[WIDTH-2:0], fb}.
REQ-017 SHALL compute the Galois step (MODE=1) as: next = {1'b0, state[WIDTH-1:1]} XOR ({WIDTH{state[0]}} AND TAPS).
REQ-018 SHALL accept i_load only in RUN; on acceptance: latch i_seed, clear o_valid, enter LOAD, and set the counter to 0.
REQ-019 SHALL, on cycle k of LOAD (k = 0..WIDTH-1), set state = {state[WIDTH-2:0], seed_latch[WIDTH-1-k]}, MSB first.
REQ-020 SHALL return to RUN after exactly WIDTH LOAD cycles with state equal to the latched seed, making load latency WIDTH cycles.
REQ-021 SHALL substitute DEFAULT_SEED for the final state at the end of LOAD if the latched seed is all-zero (no lock-up).
REQ-022 SHALL ignore i_load, i_en and i_ready-driven steps during LOAD; o_valid stays 0.
REQ-023 SHALL step in RUN when i_en=1 and (o_valid=0 or i_ready=1); the step updates state, o_rand <= next, and o_valid <= 1 on the same edge.
REQ-024 SHALL clear o_valid when o_valid=1, i_ready=1 and no step occurs.
REQ-025 SHALL hold o_rand and o_valid stable while o_valid=1 and i_ready=0, and stall stepping.
REQ-026 SHALL give i_load priority over a step when i_load and a step-eligible i_en arrive in the same RUN cycle.
REQ-027 SHALL hold a seed register set to the seed at end of LOAD (or DEFAULT_SEED at reset); o_wrap pulses on the step whose next state equals the seed register.
REQ-028 SHALL generate o_busy combinationally from the FSM state (LOAD = 1).

Reset
REQ-029 SHALL, while rst=0 regardless of clk, force: FSM = RUN, state = DEFAULT_SEED, seed register = DEFAULT_SEED, counter = 0, o_rand = 0, o_valid = 0, o_wrap = 0, o_busy = 0.
REQ-030 SHALL abort a LOAD in progress when rst is asserted mid-load; after release the block is in RUN with DEFAULT_SEED.
REQ-031 SHALL require only a single clk edge after rst deassertion before stepping is legal.

Verification
REQ-032 SHALL cover: WIDTH=8, TAPS=B8, MODE=0, after reset, i_en=1, i_ready=1 -> o_rand sequence 02, 04, 08, 11, with o_valid=1 from the first step edge.
REQ-033 SHALL cover: same configuration, run 255 steps -> o_wrap pulses exactly once, on step 255 (o_rand=01); no value repeats before that.
REQ-034 SHALL cover: i_load=1 with i_seed=A5 -> o_busy=1 for 8 cycles, and the next step yields o_rand = A5 stepped once = 4A.
REQ-035 SHALL cover: i_load with i_seed=00 -> state after LOAD = 01, and the next step yields o_rand = 02.
REQ-036 SHALL cover: o_valid=1 and i_ready=0 for 5 cycles with i_en=1 -> o_rand is unchanged, and releasing i_ready advances exactly one value per cycle.
REQ-037 SHALL cover: rst=0 asserted on LOAD cycle 3 -> outputs zero immediately, and after release the first step gives 02.
